// File: rtl/fpu_pkg.sv
// Shared FPU definitions: control-state encodings, operand classes and
// format-dependent constants for the execute-stage floating-point units.
package fpu_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_DENORM = 3'd1,
        CLS_NORMAL = 3'd2,
        CLS_INF    = 3'd3,
        CLS_QNAN   = 3'd4,
        CLS_SNAN   = 3'd5
    } fp_class_t;

    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN, right-aligned in 64 bits; callers truncate to width.
    function automatic logic [63:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
        logic [63:0] v;
        v = '0;
        for (int unsigned i = 0; i < exp_w; i++) begin
            v = v | (64'd1 << (man_w + i));
        end
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fpu_classify.sv
// Combinational IEEE-754 operand classifier, shared by the FPU execute units.
module fpu_classify
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] operand,
    output logic [2:0]           op_class,
    output logic                 sign
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] frac_f;
    fp_class_t        cls;

    always_comb begin
        exp_f  = operand[EXP_W+MAN_W-1:MAN_W];
        frac_f = operand[MAN_W-1:0];
        sign   = operand[EXP_W+MAN_W];
        cls    = CLS_NORMAL;
        if (exp_f == '0) begin
            cls = (frac_f == '0) ? CLS_ZERO : CLS_DENORM;
        end else if (exp_f == '1) begin
            if (frac_f == '0)
                cls = CLS_INF;
            else if (frac_f[MAN_W-1])
                cls = CLS_QNAN;
            else
                cls = CLS_SNAN;
        end
        op_class = cls;
    end

endmodule

// File: rtl/fpu_sqrt_iter.sv
// Multi-cycle IEEE-754 square root: radix-2 restoring recurrence, one root bit
// per cycle, round-to-nearest-even, valid/ready on both sides.
module fpu_sqrt_iter
    import fpu_pkg::*;
#(
    parameter  int unsigned EXP_W = 8,
    parameter  int unsigned MAN_W = 23,
    localparam int unsigned W     = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_invalid,
    output logic         out_inexact
);

    localparam int unsigned RW    = MAN_W + 4;
    localparam int unsigned QW    = MAN_W + 2;
    localparam int unsigned XW    = 2 * QW;
    localparam int unsigned CNT_W = $clog2(MAN_W + 2);
    localparam logic [CNT_W-1:0]      LAST_ITER = CNT_W'(MAN_W + 1);
    localparam logic signed [EXP_W:0] BIAS_S    = (EXP_W + 1)'(fp_bias(EXP_W));
    localparam logic [W-1:0]          QNAN      = W'(fp_qnan(EXP_W, MAN_W));

    logic [1:0]       state;
    logic [CNT_W-1:0] iter_cnt;
    logic [XW-1:0]    x_reg;
    logic [QW-1:0]    q_reg;
    logic [RW-1:0]    rem_reg;
    logic [EXP_W-1:0] exp_reg;

    logic [2:0]       cls_bits;
    fp_class_t        cls;
    logic             in_sign;

    fpu_classify #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_classify (
        .operand  (in_a),
        .op_class (cls_bits),
        .sign     (in_sign)
    );

    logic signed [EXP_W:0] e_unb;
    logic [QW-1:0]         rad;
    logic [EXP_W-1:0]      exp_next;
    logic [RW+1:0]         rem_sh;
    logic [RW+1:0]         trial;
    logic [RW+1:0]         diff;
    logic                  root_bit;
    logic [RW-1:0]         rem_next;
    logic                  round_up;
    logic                  carry;
    logic [MAN_W-1:0]      frac_rnd;
    logic [EXP_W-1:0]      exp_rnd;

    assign in_ready = (state == ST_IDLE);

    always_comb begin
        cls   = fp_class_t'(cls_bits);
        e_unb = $signed({1'b0, in_a[W-2:MAN_W]}) - BIAS_S;
        // Odd exponent: radicand doubles and e drops by one; floor(e/2) from the
        // arithmetic shift already equals (e-1)/2, so no explicit decrement.
        rad      = e_unb[0] ? {1'b1, in_a[MAN_W-1:0], 1'b0} : {1'b0, 1'b1, in_a[MAN_W-1:0]};
        exp_next = EXP_W'((e_unb >>> 1) + BIAS_S);

        rem_sh   = {rem_reg, x_reg[XW-1:XW-2]};
        trial    = {2'b00, q_reg, 2'b01};
        diff     = rem_sh - trial;
        root_bit = (rem_sh >= trial);
        rem_next = root_bit ? RW'(diff) : RW'(rem_sh);

        round_up           = q_reg[0] & ((rem_reg != '0) | q_reg[1]);
        {carry, frac_rnd}  = {1'b0, q_reg[MAN_W:1]} + (MAN_W + 1)'(round_up);
        exp_rnd            = exp_reg + EXP_W'(carry);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            iter_cnt    <= '0;
            x_reg       <= '0;
            q_reg       <= '0;
            rem_reg     <= '0;
            exp_reg     <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_invalid <= 1'b0;
            out_inexact <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        iter_cnt    <= '0;
                        out_inexact <= 1'b0;
                        out_invalid <= 1'b0;
                        state       <= ST_DONE;
                        out_valid   <= 1'b1;
                        case (cls)
                            CLS_ZERO, CLS_DENORM: out_result <= {in_sign, {(W-1){1'b0}}};
                            CLS_INF: begin
                                out_result  <= in_sign ? QNAN : in_a;
                                out_invalid <= in_sign;
                            end
                            CLS_QNAN: out_result <= QNAN;
                            CLS_SNAN: begin
                                out_result  <= QNAN;
                                out_invalid <= 1'b1;
                            end
                            default: begin
                                if (in_sign) begin
                                    out_result  <= QNAN;
                                    out_invalid <= 1'b1;
                                end else begin
                                    state     <= ST_CALC;
                                    out_valid <= 1'b0;
                                    x_reg     <= {rad, {QW{1'b0}}};
                                    q_reg     <= '0;
                                    rem_reg   <= '0;
                                    exp_reg   <= exp_next;
                                end
                            end
                        endcase
                    end
                end
                ST_CALC: begin
                    x_reg    <= {x_reg[XW-3:0], 2'b00};
                    q_reg    <= {q_reg[QW-2:0], root_bit};
                    rem_reg  <= rem_next;
                    iter_cnt <= iter_cnt + 1'b1;
                    if (iter_cnt == LAST_ITER)
                        state <= ST_ROUND;
                end
                ST_ROUND: begin
                    out_result  <= {1'b0, exp_rnd, frac_rnd};
                    out_inexact <= q_reg[0] | (rem_reg != '0);
                    out_invalid <= 1'b0;
                    out_valid   <= 1'b1;
                    state       <= ST_DONE;
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_sqrt_iter.sv
// Self-checking bench for fpu_sqrt_iter: directed vectors, handshake/reset
// scenarios and random operands against an integer-sqrt reference model.
module tb_fpu_sqrt_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_invalid;
    logic        out_inexact;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    fpu_sqrt_iter #(
        .EXP_W (8),
        .MAN_W (23)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_invalid (out_invalid),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference: exact integer square root of the scaled significand; round up
    // iff V > r*r + r (a tie is impossible since V is an integer).
    function automatic void ref_sqrt(input logic [31:0] a, output logic [31:0] r,
                                     output logic inv, output logic inx);
        logic             s;
        int               ef;
        logic [22:0]      f;
        longint unsigned  m, v, root;
        int               e, ex;
        s  = a[31];
        ef = int'(a[30:23]);
        f  = a[22:0];
        inv = 1'b0;
        inx = 1'b0;
        r   = '0;
        if (ef == 0) begin
            r = {s, 31'b0};
        end else if (ef == 255) begin
            if (f == 0 && !s) r = a;
            else begin
                r   = QNAN;
                inv = (f == 0) || !f[22];
            end
        end else if (s) begin
            r   = QNAN;
            inv = 1'b1;
        end else begin
            m = {40'd0, 1'b1, f};
            e = ef - 127;
            if (e % 2 != 0) begin
                m = m << 1;
                e = e - 1;
            end
            v    = m << 23;
            root = longint'($sqrt(real'(v)));
            while (root * root > v) root--;
            while ((root + 1) * (root + 1) <= v) root++;
            inx = (v != root * root);
            if (v > root * root + root) root++;
            ex = e / 2 + 127;
            if (root == (64'd1 << 24)) begin
                ex++;
                root = 64'd1 << 23;
            end
            r = {1'b0, ex[7:0], root[22:0]};
        end
    endfunction

    task automatic run_op(input logic [31:0] a, output logic [31:0] r,
                          output logic inv, output logic inx, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        in_a = a;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        r   = out_result;
        inv = out_invalid;
        inx = out_inexact;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [31:0] dv_a   [10] = '{32'h4080_0000, 32'h4000_0000, 32'h3E80_0000, 32'hBF80_0000,
                                 32'h8000_0000, 32'h7F80_0000, 32'h7F80_0001, 32'h0000_0001,
                                 32'h7FC0_0000, 32'hFF80_0000};
    logic [31:0] dv_r   [10] = '{32'h4000_0000, 32'h3FB5_04F3, 32'h3F00_0000, 32'h7FC0_0000,
                                 32'h8000_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0000,
                                 32'h7FC0_0000, 32'h7FC0_0000};
    logic        dv_inv [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        dv_inx [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int          dv_lat [10] = '{27, 27, 27, 1, 1, 1, 1, 1, 1, 1};

    initial begin
        logic [31:0] r, er, a, held;
        logic        inv, inx, einv, einx;
        int          lat, n;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_flags", {30'd0, out_invalid, out_inexact}, 32'd0);
        rst = 1'b0;

        // Directed vectors with fixed expected values.
        for (int i = 0; i < 10; i++) begin
            run_op(dv_a[i], r, inv, inx, lat);
            chk($sformatf("dir_res_%0d", i), r, dv_r[i]);
            chk($sformatf("dir_inv_%0d", i), 32'(inv), 32'(dv_inv[i]));
            chk($sformatf("dir_inx_%0d", i), 32'(inx), 32'(dv_inx[i]));
            chk($sformatf("dir_lat_%0d", i), 32'(lat), 32'(dv_lat[i]));
            consume();
            chk($sformatf("dir_drop_%0d", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: hold the 2.0 result for 10 cycles while poking in_valid.
        run_op(32'h4000_0000, r, inv, inx, lat);
        held = r;
        chk("bp_first", held, 32'h3FB5_04F3);
        for (int i = 0; i < 10; i++) begin
            in_a = 32'h4080_0000;
            in_valid = i[0];
            @(posedge clk); #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_result", out_result, 32'h3FB5_04F3);
            chk("bp_flags", {30'd0, out_invalid, out_inexact}, 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        consume();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);

        // Reset mid-operation, then a fresh 9.0.
        in_a = 32'h4000_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        n = 0;
        while (n < 40) begin
            chk("midrst_no_emit", 32'(out_valid), 32'd0);
            @(posedge clk); #1; n += 10;
        end
        run_op(32'h4110_0000, r, inv, inx, lat);
        chk("nine_res", r, 32'h4040_0000);
        chk("nine_flags", {30'd0, inv, inx}, 32'd0);
        chk("nine_lat", 32'(lat), 32'd27);
        consume();

        // Random operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if (i % 2 == 0) begin
                a[31] = 1'b0;
                if (a[30:23] == 8'h00 || a[30:23] == 8'hFF) a[30:23] = 8'd127;
            end
            ref_sqrt(a, er, einv, einx);
            run_op(a, r, inv, inx, lat);
            chk($sformatf("rnd_res_%h", a), r, er);
            chk($sformatf("rnd_inv_%h", a), 32'(inv), 32'(einv));
            chk($sformatf("rnd_inx_%h", a), 32'(inx), 32'(einx));
            chk($sformatf("rnd_lat_%h", a), 32'(lat),
                (a[31] == 1'b0 && a[30:23] != 8'h00 && a[30:23] != 8'hFF) ? 32'd27 : 32'd1);
            consume();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
